// File: rtl/debounce_bank_if.sv
// Switch-bank interface: raw switch levels in, debounced levels and edge/hold pulses out.
interface debounce_bank_if #(
  parameter int unsigned NUM_CH = 4
) ();
  logic [NUM_CH-1:0] sw_in;
  logic [NUM_CH-1:0] sw_out;
  logic [NUM_CH-1:0] rise_pulse;
  logic [NUM_CH-1:0] fall_pulse;
  logic [NUM_CH-1:0] hold_pulse;

  modport master (
    output sw_in,
    input  sw_out,
    input  rise_pulse,
    input  fall_pulse,
    input  hold_pulse
  );

  modport slave (
    input  sw_in,
    output sw_out,
    output rise_pulse,
    output fall_pulse,
    output hold_pulse
  );
endinterface

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: 2-FF synchroniser, per-channel stability counter, edge pulses.
// Define DEBOUNCE_HOLD_EN to add a per-channel long-press hold_pulse; otherwise it is tied low.
module debounce_bank #(
  parameter int unsigned NUM_CH          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter logic        RESET_LEVEL     = 1'b0,
  parameter int unsigned HOLD_CYCLES     = 100_000_000
) (
  input logic            clk,
  input logic            rst_n,
  debounce_bank_if.slave bus
);

  localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= {NUM_CH{RESET_LEVEL}};
      sync2_q <= {NUM_CH{RESET_LEVEL}};
    end else begin
      sync1_q <= bus.sw_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic             out_q;
    logic             rise_q;
    logic             fall_q;

    // Any sample agreeing with the current level discards the partial count.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        out_q  <= RESET_LEVEL;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sync2_q[i] == out_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_q  <= '0;
          out_q  <= sync2_q[i];
          rise_q <= sync2_q[i];
          fall_q <= ~sync2_q[i];
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign bus.sw_out[i]     = out_q;
    assign bus.rise_pulse[i] = rise_q;
    assign bus.fall_pulse[i] = fall_q;

`ifdef DEBOUNCE_HOLD_EN
    localparam int unsigned       HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

    logic [HOLD_W-1:0] hold_cnt_q;
    logic              hold_q;

    // Saturating at HOLD_MAX makes the pulse fire once per press.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_cnt_q <= '0;
        hold_q     <= 1'b0;
      end else begin
        hold_q <= out_q && (hold_cnt_q == HOLD_MAX - HOLD_W'(1));
        if (!out_q) begin
          hold_cnt_q <= '0;
        end else if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
      end
    end

    assign bus.hold_pulse[i] = hold_q;
`else
    assign bus.hold_pulse[i] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Randomised and directed bench for debounce_bank against a sample-window reference model.
module tb_debounce_bank;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned D      = 8;
  localparam int unsigned H      = 20;
  localparam logic        RST_LV = 1'b0;
`ifdef DEBOUNCE_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  debounce_bank_if #(.NUM_CH(NUM_CH)) bus ();

  debounce_bank #(
    .NUM_CH         (NUM_CH),
    .DEBOUNCE_CYCLES(D),
    .RESET_LEVEL    (RST_LV),
    .HOLD_CYCLES    (H)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: pipe[ch][k] is sw_in as sampled k edges ago. A new level is accepted
  // when the last D synchronised samples (pipe[2..D+1]) all disagree with the current level.
  logic              pipe [NUM_CH][D+2];
  logic [NUM_CH-1:0] m_out, m_rise, m_fall, m_hold;
  int                rise_at [NUM_CH];
  int                ecount = 0;

  task automatic model_reset();
    m_out  = {NUM_CH{RST_LV}};
    m_rise = '0;
    m_fall = '0;
    m_hold = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rise_at[c] = -1000;
      for (int j = 0; j < D + 2; j++) pipe[c][j] = RST_LV;
    end
  endtask

  task automatic model_step();
    bit all_diff;
    ecount++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = D + 1; j > 0; j--) pipe[c][j] = pipe[c][j-1];
      pipe[c][0] = bus.sw_in[c];
      all_diff = 1'b1;
      for (int j = 2; j < D + 2; j++) if (pipe[c][j] == m_out[c]) all_diff = 1'b0;
      m_hold[c] = HoldEn && m_out[c] && (ecount - rise_at[c] == H);
      m_rise[c] = 1'b0;
      m_fall[c] = 1'b0;
      if (all_diff) begin
        m_out[c] = ~m_out[c];
        if (m_out[c]) begin
          m_rise[c]  = 1'b1;
          rise_at[c] = ecount;
        end else begin
          m_fall[c] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("sw_out", 32'(bus.sw_out), 32'(m_out));
    check("rise_pulse", 32'(bus.rise_pulse), 32'(m_rise));
    check("fall_pulse", 32'(bus.fall_pulse), 32'(m_fall));
    check("hold_pulse", 32'(bus.hold_pulse), 32'(m_hold));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    ticks(2);
    rst_n = 1'b1;
  endtask

  int cnt, idx_a, idx_b, gap;
  int run [NUM_CH];

  initial begin
    rst_n     = 1'b0;
    bus.sw_in = 2'b11;
    model_reset();
    #1;
    check("reset_sw_out", 32'(bus.sw_out), 32'h0);
    check("reset_pulses", 32'({bus.rise_pulse, bus.fall_pulse, bus.hold_pulse}), 32'h0);
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1;

    // Step on both channels: rise expected at the 10th sampling edge.
    idx_a = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (idx_a < 0 && bus.rise_pulse == 2'b11) idx_a = k;
    end
    check("rise_latency", 32'(idx_a), 32'd10);

    bus.sw_in = 2'b00;
    ticks(14);

    // 7-sample glitch is rejected, 8-sample pulse is accepted.
    bus.sw_in[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 7; k++) begin tick(); cnt += int'(bus.rise_pulse[0]); end
    bus.sw_in[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin tick(); cnt += int'(bus.rise_pulse[0]); end
    check("glitch7_rises", 32'(cnt), 32'd0);
    bus.sw_in[0] = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin tick(); cnt += int'(bus.rise_pulse[0]); end
    bus.sw_in[0] = 1'b0;
    for (int k = 0; k < 14; k++) begin tick(); cnt += int'(bus.rise_pulse[0]); end
    check("pulse8_rises", 32'(cnt), 32'd1);

    // Bouncing fall on channel 1.
    bus.sw_in[1] = 1'b1;
    ticks(12);
    cnt = 0;
    for (int b = 0; b < 4; b++) begin
      bus.sw_in[1] = b[0];
      for (int k = 0; k < 2; k++) begin tick(); cnt += int'(bus.fall_pulse[1]); end
    end
    bus.sw_in[1] = 1'b0;
    idx_a = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      cnt += int'(bus.fall_pulse[1]);
      if (idx_a < 0 && bus.fall_pulse[1]) idx_a = k;
    end
    check("bounce_falls", 32'(cnt), 32'd1);
    check("bounce_latency", 32'(idx_a), 32'd10);

    // Opposite edges on the two channels in the same cycle.
    bus.sw_in = 2'b10;
    ticks(12);
    bus.sw_in = 2'b01;
    idx_a = -1;
    idx_b = -2;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (idx_a < 0 && bus.rise_pulse[0]) idx_a = k;
      if (idx_b < 0 && bus.fall_pulse[1]) idx_b = k;
    end
    check("cross_same_cycle", 32'(idx_a), 32'(idx_b));
    check("cross_latency", 32'(idx_a), 32'd10);

    // Reset mid-count aborts, then a full latency is needed again.
    bus.sw_in = 2'b00;
    ticks(12);
    bus.sw_in[0] = 1'b1;
    ticks(7);
    async_reset();
    idx_a = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (idx_a < 0 && bus.rise_pulse[0]) idx_a = k;
    end
    check("post_reset_latency", 32'(idx_a), 32'd10);

    // Long press on channel 0.
    bus.sw_in = 2'b00;
    ticks(12);
    bus.sw_in[0] = 1'b1;
    idx_a = -1;
    idx_b = -1;
    cnt   = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (idx_a < 0 && bus.rise_pulse[0]) idx_a = k;
      if (bus.hold_pulse[0]) begin
        cnt++;
        if (idx_b < 0) idx_b = k;
      end
    end
    gap = (idx_b < 0) ? -1 : idx_b - idx_a;
    check("hold_count", 32'(cnt), HoldEn ? 32'd1 : 32'd0);
    check("hold_gap", 32'(gap), HoldEn ? 32'(H) : 32'hFFFF_FFFF);

    // Random runs mixing short glitches and stable levels, with occasional resets.
    for (int c = 0; c < NUM_CH; c++) run[c] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (run[c] == 0) begin
          bus.sw_in[c] = 1'($urandom_range(0, 1));
          run[c]       = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40)
                                                     : $urandom_range(1, 14);
        end
        run[c]--;
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      else tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
